// File: rtl/superbug_sound.sv
// Super Bug discrete-sound replacement.
// Three voices (motor triangle, decaying crash noise, skid noise) are mixed into a
// 6-bit level that drives a first-order sigma-delta DAC. Everything runs on Clk6.
module superbug_sound #(
  parameter int unsigned PRESCALE    = 64,   // Clk6 cycles per sound tick, power of two
  parameter int unsigned DECAY_TICKS = 2048  // ticks per crash amplitude step, power of two
) (
  input  logic       Clk6,
  input  logic       Reset_n,
  input  logic [7:0] DBus,
  input  logic       MotorSnd_n,
  input  logic       CrashSnd_n,
  input  logic       SkidSnd_n,
  input  logic       Attract,
  output logic [5:0] Audio_Level,
  output logic       Audio_O
);

  localparam int unsigned PW = $clog2(PRESCALE);
  localparam int unsigned DW = $clog2(DECAY_TICKS);
  localparam logic [PW-1:0] PresLast  = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DecayLast = DW'(DECAY_TICKS - 1);
  localparam logic [15:0]   LfsrSeed  = 16'hACE1;

  // ---------------------------------------------------------------------------
  // Tick generation
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc_q;
  logic          tick;

  assign tick = (presc_q == PresLast);

  // Free-running prescaler; wraps naturally because PRESCALE is a power of two.
  always_ff @(posedge Clk6 or negedge Reset_n) begin
    if (!Reset_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Strobe edge detection
  // ---------------------------------------------------------------------------
  logic motor_prev_q;
  logic crash_prev_q;
  logic motor_load;
  logic crash_load;

  // A load fires only on the first low cycle, so long strobes load exactly once.
  assign motor_load = ~MotorSnd_n & motor_prev_q;
  assign crash_load = ~CrashSnd_n & crash_prev_q;

  // Remember last strobe levels; idle-high after reset so no spurious load.
  always_ff @(posedge Clk6 or negedge Reset_n) begin
    if (!Reset_n) begin
      motor_prev_q <= 1'b1;
      crash_prev_q <= 1'b1;
    end else begin
      motor_prev_q <= MotorSnd_n;
      crash_prev_q <= CrashSnd_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Motor voice
  // ---------------------------------------------------------------------------
  logic [3:0]  speed_q;
  logic [15:0] phase_q;
  logic [15:0] phase_inc;
  logic [3:0]  motor_tri;

  // 40 + 24*speed spans 40..400 per tick.
  assign phase_inc = 16'd40 + 16'(speed_q) * 16'd24;
  assign motor_tri = phase_q[15] ? ~phase_q[14:11] : phase_q[14:11];

  // Speed latch; a load on a tick edge leaves that tick's add with the old speed.
  always_ff @(posedge Clk6 or negedge Reset_n) begin
    if (!Reset_n) begin
      speed_q <= '0;
    end else if (motor_load) begin
      speed_q <= DBus[3:0];
    end
  end

  // Phase accumulator advances once per tick, wrapping mod 2^16.
  always_ff @(posedge Clk6 or negedge Reset_n) begin
    if (!Reset_n) begin
      phase_q <= '0;
    end else if (tick) begin
      phase_q <= phase_q + phase_inc;
    end
  end

  // ---------------------------------------------------------------------------
  // Noise source
  // ---------------------------------------------------------------------------
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  // Taps 16,14,13,11 counted from the output end of a right-shifting register.
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  // Fibonacci LFSR shifted once per tick; non-zero seed keeps it off the lock-up state.
  always_ff @(posedge Clk6 or negedge Reset_n) begin
    if (!Reset_n) begin
      lfsr_q <= LfsrSeed;
    end else if (tick) begin
      lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Crash amplitude with stepwise decay
  // ---------------------------------------------------------------------------
  logic [3:0]    amp_q;
  logic [DW-1:0] decay_q;

  // A load takes priority over a coinciding decay wrap and restarts the decay period.
  always_ff @(posedge Clk6 or negedge Reset_n) begin
    if (!Reset_n) begin
      amp_q   <= '0;
      decay_q <= '0;
    end else if (crash_load) begin
      amp_q   <= DBus[3:0];
      decay_q <= '0;
    end else if (tick) begin
      decay_q <= decay_q + DW'(1);
      if ((decay_q == DecayLast) && (amp_q != 4'd0)) begin
        amp_q <= amp_q - 4'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Mixer
  // ---------------------------------------------------------------------------
  logic [3:0] motor_v;
  logic [3:0] crash_v;
  logic [3:0] skid_v;
  logic [5:0] level_d;
  logic [5:0] level_q;

  // Gate the voices and sum them; 15+15+14 fits in 6 bits.
  always_comb begin
    motor_v = Attract ? 4'd0 : motor_tri;
    crash_v = lfsr_q[0] ? amp_q : 4'd0;
    skid_v  = (!Attract && !SkidSnd_n) ? {lfsr_q[3:1], 1'b0} : 4'd0;
    level_d = {2'b00, motor_v} + {2'b00, crash_v} + {2'b00, skid_v};
  end

  // Mix register, updated every cycle.
  always_ff @(posedge Clk6 or negedge Reset_n) begin
    if (!Reset_n) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign Audio_Level = level_q;

  // ---------------------------------------------------------------------------
  // First-order sigma-delta DAC
  // ---------------------------------------------------------------------------
  logic [5:0] dac_q;
  logic [6:0] dac_sum;
  logic       out_q;

  assign dac_sum = {1'b0, dac_q} + {1'b0, level_q};

  // The accumulator carry is the bitstream: density = level / 64.
  always_ff @(posedge Clk6 or negedge Reset_n) begin
    if (!Reset_n) begin
      dac_q <= '0;
      out_q <= 1'b0;
    end else begin
      dac_q <= dac_sum[5:0];
      out_q <= dac_sum[6];
    end
  end

  assign Audio_O = out_q;

endmodule
